// File: rtl/pixel_config_scheduler.sv
// pixel_config_scheduler
// Runs one pixel-configuration pass. It walks a config-RAM address range,
// pushes each word into the pixel-config FIFO and kicks the serial shifter.
// It then waits for the FIFO to drain and reports DONE.
// Optional feature macro: PIXCFG_BROADCAST_EN. When defined, the BCAST and
// BCAST_DATA ports are added and a pass can write one fixed word N times
// without reading the RAM.
module pixel_config_scheduler #(
  parameter int DATA_WIDTH   = 15,
  parameter int ADDR_WIDTH   = 12,
  parameter int DRAIN_CYCLES = 24,
  parameter int DCNT_WIDTH   = 5
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [ADDR_WIDTH-1:0] FIRST_ADDR,
  input  logic [ADDR_WIDTH:0]   NUM_PIXELS,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_RD_EN,
  input  logic [DATA_WIDTH-1:0] RAM_DATA,
  output logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  FIFO_WR_EN,
  input  logic                  FIFO_FULL,
  input  logic                  FIFO_EMPTY,
`ifdef PIXCFG_BROADCAST_EN
  input  logic                  BCAST,
  input  logic [DATA_WIDTH-1:0] BCAST_DATA,
`endif
  output logic                  SHIFT_START,
  output logic                  BUSY_O,
  output logic                  DONE,
  output logic                  ABORTED,
  output logic [ADDR_WIDTH:0]   PIX_COUNT
);

  // state   | meaning
  // IDLE    | waiting for START; pass parameters latched on START
  // FETCH   | RAM read strobe issued for the current address
  // CAPT    | RAM word captured into the hold register, address advanced
  // WRITE   | hold word written to the FIFO once it is not full
  // DRAIN   | waiting for FIFO empty, then DRAIN_CYCLES quiet cycles
  // FIN     | pass complete; DONE is pulsed as the FSM returns to IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [DCNT_WIDTH-1:0] DCNT_LOAD = DCNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [DCNT_WIDTH-1:0] DCNT_ONE  = DCNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic [DATA_WIDTH-1:0]   hold;
  logic [DCNT_WIDTH-1:0]   dcnt;
  logic                    bcast_mode;
  logic                    bcast_req;
  logic                    start_pass;
  logic                    abort_pass;
  logic                    write_fire;
  logic                    capt_fire;

`ifdef PIXCFG_BROADCAST_EN
  assign bcast_req = BCAST;
`else
  assign bcast_req = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the per-cycle events that drive the datapath.
  always_comb begin
    state_nxt  = state;
    start_pass = 1'b0;
    abort_pass = 1'b0;
    write_fire = 1'b0;
    capt_fire  = 1'b0;
    if (state != S_IDLE && ABORT) begin
      abort_pass = 1'b1;
      state_nxt  = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            start_pass = 1'b1;
            if (NUM_PIXELS == '0) begin
              state_nxt = S_FIN;
            end else if (bcast_req) begin
              state_nxt = S_WRITE;
            end else begin
              state_nxt = S_FETCH;
            end
          end
        end
        S_FETCH: state_nxt = S_CAPT;
        S_CAPT: begin
          capt_fire = 1'b1;
          state_nxt = S_WRITE;
        end
        S_WRITE: begin
          if (!FIFO_FULL) begin
            write_fire = 1'b1;
            if (remaining == CNT_ONE) begin
              state_nxt = S_DRAIN;
            end else if (bcast_mode) begin
              state_nxt = S_WRITE;
            end else begin
              state_nxt = S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (FIFO_EMPTY && dcnt == '0) begin
            state_nxt = S_FIN;
          end
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs. Strobes are decoded from the next state
  // or from this cycle's events, so every output is a flop.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      addr        <= '0;
      remaining   <= '0;
      hold        <= '0;
      dcnt        <= DCNT_LOAD;
      bcast_mode  <= 1'b0;
      RAM_ADDR    <= '0;
      RAM_RD_EN   <= 1'b0;
      FIFO_DATA   <= '0;
      FIFO_WR_EN  <= 1'b0;
      SHIFT_START <= 1'b0;
      BUSY_O      <= 1'b0;
      DONE        <= 1'b0;
      ABORTED     <= 1'b0;
      PIX_COUNT   <= '0;
    end else begin
      RAM_RD_EN   <= (state_nxt == S_FETCH);
      FIFO_WR_EN  <= write_fire;
      // Kick the shifter after each write. Keep kicking during the drain
      // while words remain, in case it went idle on a transient empty.
      SHIFT_START <= FIFO_WR_EN | ((state == S_DRAIN) & ~FIFO_EMPTY & ~abort_pass);
      BUSY_O      <= (state_nxt != S_IDLE);
      DONE        <= (state == S_FIN) & ~abort_pass;
      ABORTED     <= abort_pass;

      if (state_nxt == S_FETCH) begin
        RAM_ADDR <= (state == S_IDLE) ? FIRST_ADDR : addr;
      end

      if (start_pass) begin
        addr       <= FIRST_ADDR;
        remaining  <= NUM_PIXELS;
        PIX_COUNT  <= '0;
        bcast_mode <= bcast_req;
`ifdef PIXCFG_BROADCAST_EN
        if (BCAST) begin
          hold <= BCAST_DATA;
        end
`endif
      end

      if (capt_fire) begin
        hold <= RAM_DATA;
        addr <= addr + ADDR_ONE;
      end

      if (write_fire) begin
        FIFO_DATA <= hold;
        PIX_COUNT <= PIX_COUNT + CNT_ONE;
        remaining <= remaining - CNT_ONE;
      end

      // Drain timer: a down-counter that reloads whenever the FIFO is not
      // empty, so FIN needs DRAIN_CYCLES consecutive empty cycles.
      if (state != S_DRAIN || !FIFO_EMPTY) begin
        dcnt <= DCNT_LOAD;
      end else if (dcnt != '0) begin
        dcnt <= dcnt - DCNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pixel_config_scheduler.sv
// Self-checking bench for pixel_config_scheduler. The stimulus pushes the
// expected RAM addresses and FIFO words into queues. A negedge monitor pops
// and compares them whenever the DUT strobes RAM_RD_EN or FIFO_WR_EN.
module tb_pixel_config_scheduler;
  localparam int DW = 15;
  localparam int AW = 12;

  logic          CLK_IN = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [AW-1:0] FIRST_ADDR = '0;
  logic [AW:0]   NUM_PIXELS = '0;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_RD_EN;
  logic [DW-1:0] RAM_DATA = '0;
  logic [DW-1:0] FIFO_DATA;
  logic          FIFO_WR_EN;
  logic          FIFO_FULL;
  logic          FIFO_EMPTY;
  logic          SHIFT_START;
  logic          BUSY_O;
  logic          DONE;
  logic          ABORTED;
  logic [AW:0]   PIX_COUNT;
`ifdef PIXCFG_BROADCAST_EN
  logic          BCAST = 1'b0;
  logic [DW-1:0] BCAST_DATA = '0;
`endif

  pixel_config_scheduler dut (
    .CLK_IN(CLK_IN), .RESET(RESET), .START(START), .ABORT(ABORT),
    .FIRST_ADDR(FIRST_ADDR), .NUM_PIXELS(NUM_PIXELS),
    .RAM_ADDR(RAM_ADDR), .RAM_RD_EN(RAM_RD_EN), .RAM_DATA(RAM_DATA),
    .FIFO_DATA(FIFO_DATA), .FIFO_WR_EN(FIFO_WR_EN),
    .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
`ifdef PIXCFG_BROADCAST_EN
    .BCAST(BCAST), .BCAST_DATA(BCAST_DATA),
`endif
    .SHIFT_START(SHIFT_START), .BUSY_O(BUSY_O), .DONE(DONE),
    .ABORTED(ABORTED), .PIX_COUNT(PIX_COUNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  // Config RAM: registered read, data valid the cycle after RAM_RD_EN.
  logic [DW-1:0] mem [0:4095];
  always @(posedge CLK_IN) if (RAM_RD_EN) RAM_DATA <= mem[RAM_ADDR];

  // FIFO model: occupancy only, one word drained every 4 cycles.
  // FULL is forced by the stimulus.
  int       fifo_cnt;
  logic [1:0] pop_tmr;
  logic     full_force = 1'b0;
  logic     full_prev = 1'b0;
  always @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      fifo_cnt <= 0;
      pop_tmr  <= 2'd0;
    end else begin
      pop_tmr  <= pop_tmr + 2'd1;
      fifo_cnt <= fifo_cnt + (FIFO_WR_EN ? 1 : 0) - ((fifo_cnt != 0 && pop_tmr == 2'd3) ? 1 : 0);
    end
  end
  assign FIFO_EMPTY = (fifo_cnt == 0);
  assign FIFO_FULL  = full_force;
  always @(posedge CLK_IN) full_prev <= FIFO_FULL;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues and monitor state.
  logic [31:0] exp_wr[$];
  logic [31:0] exp_addr[$];
  int          wr_cyc[$];
  logic [31:0] mon_e;
  int  wr_cnt = 0, rd_cnt = 0, done_cnt = 0, aborted_cnt = 0;
  int  done_cyc = 0, empty_rise_cyc = 0;
  logic prev_wr = 1'b0, empty_prev = 1'b1;

  always @(negedge CLK_IN) begin
    if (RESET) begin
      prev_wr    = 1'b0;
      empty_prev = 1'b1;
    end else begin
      if (prev_wr) check("shift_after_write", SHIFT_START, 1);
      if (FIFO_WR_EN) begin
        check("write_while_full", full_prev, 0);
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_e = exp_wr.pop_front();
          check("fifo_data", FIFO_DATA, mon_e);
        end
        wr_cyc.push_back(cyc);
        wr_cnt++;
      end
      if (RAM_RD_EN) begin
        if (exp_addr.size() == 0) check("unexpected_ram_read", 1, 0);
        else begin
          mon_e = exp_addr.pop_front();
          check("ram_addr", RAM_ADDR, mon_e);
        end
        rd_cnt++;
      end
      if (FIFO_EMPTY && !empty_prev) empty_rise_cyc = cyc;
      empty_prev = FIFO_EMPTY;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ABORTED) aborted_cnt++;
      prev_wr = FIFO_WR_EN;
    end
  end

  // Stimulus steps land 1 ns after the negedge, so the monitor has already run.
  task automatic tick();
    @(negedge CLK_IN);
    #1;
  endtask

  int t_start;
  task automatic start_pass(input logic [AW-1:0] fa, input logic [AW:0] np);
    tick();
    FIRST_ADDR = fa;
    NUM_PIXELS = np;
    START = 1'b1;
    t_start = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (DONE || ABORTED) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, ok, 1);
  endtask

  task automatic check_queues(input string name);
    check({name, "_exp_wr_left"}, exp_wr.size(), 0);
    check({name, "_exp_addr_left"}, exp_addr.size(), 0);
  endtask

  int base_done, base_ab, base_wr, base_rd;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 15'h1234; mem[12'h011] = 15'h0ABC; mem[12'h012] = 15'h7FFF;
    mem[12'h100] = 15'h0111; mem[12'h101] = 15'h0222;
    mem[12'h102] = 15'h0333; mem[12'h103] = 15'h0444;
    mem[12'hFFF] = 15'h0F0F; mem[12'h000] = 15'h00AA;
    mem[12'h200] = 15'h2001; mem[12'h201] = 15'h2002; mem[12'h202] = 15'h2003;

    // Reset state: every output low.
    repeat (3) tick();
    check("reset_outputs", {RAM_ADDR, RAM_RD_EN, FIFO_DATA, FIFO_WR_EN, SHIFT_START,
                            BUSY_O, DONE, ABORTED, PIX_COUNT}, 0);
    RESET = 1'b0;
    repeat (2) tick();

    // Test 1: three words from 0x010, writes 3 cycles apart.
    wr_cyc.delete();
    base_done = done_cnt;
    exp_addr.push_back(12'h010); exp_addr.push_back(12'h011); exp_addr.push_back(12'h012);
    exp_wr.push_back(15'h1234);  exp_wr.push_back(15'h0ABC);  exp_wr.push_back(15'h7FFF);
    start_pass(12'h010, 13'd3);
    check("t1_busy", BUSY_O, 1);
    wait_end(300, "t1_timeout");
    check("t1_done_count", done_cnt - base_done, 1);
    check("t1_pix_count", PIX_COUNT, 3);
    check("t1_writes", wr_cyc.size(), 3);
    check("t1_gap0", wr_cyc[1] - wr_cyc[0], 3);
    check("t1_gap1", wr_cyc[2] - wr_cyc[1], 3);
    // 24 counted empty cycles, one FIN cycle, then the registered DONE.
    check("t1_drain_latency", done_cyc - empty_rise_cyc, 25);
    tick();
    check("t1_done_one_cycle", DONE, 0);
    check_queues("t1");

    // Test 2: FIFO full for 10 cycles while word 2 of 4 is pending.
    wr_cyc.delete();
    base_wr = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'h100 + i);
      exp_wr.push_back({17'd0, mem[12'h100 + i]});
    end
    start_pass(12'h100, 13'd4);
    for (int i = 0; i < 20 && wr_cnt == base_wr; i++) tick();
    full_force = 1'b1;
    repeat (10) tick();
    full_force = 1'b0;
    wait_end(400, "t2_timeout");
    check("t2_writes", wr_cnt - base_wr, 4);
    check("t2_pix_count", PIX_COUNT, 4);
    // Word 2 is fetched/captured in 2 cycles, then stalls until FULL drops.
    check("t2_stall_gap", wr_cyc[1] - wr_cyc[0], 11);
    check_queues("t2");
    repeat (2) tick();

    // Test 3: address wrap from 0xFFF to 0x000.
    exp_addr.push_back(12'hFFF); exp_addr.push_back(12'h000);
    exp_wr.push_back(15'h0F0F);  exp_wr.push_back(15'h00AA);
    start_pass(12'hFFF, 13'd2);
    wait_end(300, "t3_timeout");
    check("t3_pix_count", PIX_COUNT, 2);
    check_queues("t3");
    repeat (2) tick();

    // Test 4: zero-length pass completes with no RAM or FIFO traffic.
    base_wr = wr_cnt; base_rd = rd_cnt; base_done = done_cnt;
    start_pass(12'h055, 13'd0);
    check("t4_busy_fin", BUSY_O, 1);
    wait_end(10, "t4_timeout");
    check("t4_done_latency", done_cyc - t_start, 2);
    check("t4_pix_count", PIX_COUNT, 0);
    check("t4_no_traffic", (wr_cnt - base_wr) + (rd_cnt - base_rd), 0);
    repeat (2) tick();

    // Test 5: abort after word 1 of 5; a mid-pass START is ignored.
    base_done = done_cnt; base_ab = aborted_cnt; base_wr = wr_cnt;
    exp_addr.push_back(12'h200); exp_addr.push_back(12'h201);
    exp_wr.push_back(15'h2001);
    start_pass(12'h200, 13'd5);
    FIRST_ADDR = 12'h300; NUM_PIXELS = 13'd1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 20 && wr_cnt == base_wr; i++) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("t5_aborted_pulse", ABORTED, 1);
    check("t5_idle_after_abort", BUSY_O, 0);
    repeat (40) tick();
    check("t5_no_done", done_cnt - base_done, 0);
    check("t5_abort_count", aborted_cnt - base_ab, 1);
    check("t5_pix_count", PIX_COUNT, 1);
    check_queues("t5");

    // Reset mid-pass: outputs clear at once, no DONE/ABORTED.
    base_done = done_cnt; base_ab = aborted_cnt;
    exp_addr.push_back(12'h010);
    start_pass(12'h010, 13'd3);
    tick();
    RESET = 1'b1;
    #1;
    check("reset_mid_pass", {RAM_ADDR, RAM_RD_EN, FIFO_DATA, FIFO_WR_EN, SHIFT_START,
                             BUSY_O, DONE, ABORTED, PIX_COUNT}, 0);
    repeat (2) tick();
    RESET = 1'b0;
    repeat (5) tick();
    check("reset_no_pulses", (done_cnt - base_done) + (aborted_cnt - base_ab), 0);
    check_queues("t5r");

`ifdef PIXCFG_BROADCAST_EN
    // Test 6: broadcast writes 0x5555 four times back to back, no RAM reads.
    wr_cyc.delete();
    base_rd = rd_cnt;
    for (int i = 0; i < 4; i++) exp_wr.push_back(15'h5555);
    BCAST = 1'b1; BCAST_DATA = 15'h5555;
    start_pass(12'h000, 13'd4);
    BCAST = 1'b0;
    wait_end(300, "t6_timeout");
    check("t6_no_reads", rd_cnt - base_rd, 0);
    check("t6_pix_count", PIX_COUNT, 4);
    for (int i = 1; i < 4; i++) check("t6_gap", wr_cyc[i] - wr_cyc[i-1], 1);
    check_queues("t6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
